// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encodings, mode constants and byte width,
// common to the mode-0 slave and master blocks.
package spi_pkg;

  localparam int BYTE_W = 8;

  // Mode 0: clock idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'h1,
    ST_LOAD      = 3'h2,
    ST_SHIFT     = 3'h3,
    ST_BYTE_DONE = 3'h4
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with a history flop
// so the conditioned level can be turned into single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   hist_p1;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= {SYNC_STAGES{RST_VAL}};
      hist_p1 <= RST_VAL;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
      hist_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign level = sync_p0[SYNC_STAGES-1];
  assign rise  = level & ~hist_p1;
  assign fall  = ~level & hist_p1;

endmodule

// File: rtl/spi_slave_cpol0_cpha0.sv
// SPI mode-0 byte-oriented responder. Oversamples sclk/cs_n/mosi with clk,
// shifts mosi in and miso out MSB-first, and serves miso from a one-byte
// holding register that falls back to IDLE_BYTE when nothing was queued.
module spi_slave_cpol0_cpha0
  import spi_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] IDLE_BYTE   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              underrun,
  output logic [2:0]        state
);

  // ---- input conditioning ----
  logic sclk_level_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_level;
  logic cs_rise;
  logic cs_fall;
  logic mosi_level;
  logic mosi_rise_unused;
  logic mosi_fall_unused;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .din   (sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // cs_n idles high, so its chain resets to the deselected level.
  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b1)
  ) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .din   (cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // mosi only needs its level; it shares the sclk chain depth so the sample
  // taken on a detected sclk rise matches the pin value at that rise.
  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .din   (mosi),
    .level (mosi_level),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  // ---- protocol FSM and datapath ----
  spi_state_e        state_q;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] rx_sh;
  // Bits still to be sent after the one currently on miso.
  logic [BYTE_W-2:0] tx_sh;
  logic [BYTE_W-1:0] hold;

  assign state = state_q;

  // Single-process FSM: states, shifters, holding register and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
      tx_ready <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      underrun <= 1'b0;
      bit_cnt  <= '0;
      rx_sh    <= '0;
      tx_sh    <= '0;
      hold     <= '0;
    end else begin
      rx_valid <= 1'b0;
      underrun <= 1'b0;

      // Host-side write into the holding register; ignored while full.
      if (tx_load && tx_ready) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end

      // Deselect aborts any partial byte; BYTE_DONE finishes its own byte
      // and then follows the cs_n level instead.
      if (cs_rise && (state_q != ST_BYTE_DONE)) begin
        state_q <= ST_IDLE;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            bit_cnt <= '0;
            if (cs_fall) begin
              state_q <= ST_LOAD;
            end
          end

          ST_LOAD: begin
            // A byte written in this same cycle lands in hold (tx_ready is
            // still 1 here) and is served at the next byte boundary.
            if (!tx_ready) begin
              miso     <= hold[BYTE_W-1];
              tx_sh    <= hold[BYTE_W-2:0];
              tx_ready <= 1'b1;
            end else begin
              miso     <= IDLE_BYTE[BYTE_W-1];
              tx_sh    <= IDLE_BYTE[BYTE_W-2:0];
              underrun <= 1'b1;
            end
            miso_oe <= 1'b1;
            state_q <= ST_SHIFT;
          end

          ST_SHIFT: begin
            if (sclk_rise) begin
              rx_sh   <= {rx_sh[BYTE_W-2:0], mosi_level};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state_q <= ST_BYTE_DONE;
              end
            end else if (sclk_fall && (bit_cnt != 3'd0)) begin
              // With no rise yet in this byte, a fall is the trailing edge
              // of the previous byte; the new MSB is already on miso.
              miso  <= tx_sh[BYTE_W-2];
              tx_sh <= {tx_sh[BYTE_W-3:0], 1'b0};
            end
          end

          ST_BYTE_DONE: begin
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
            bit_cnt  <= '0;
            if (!cs_level) begin
              state_q <= ST_LOAD;
            end else begin
              state_q <= ST_IDLE;
              miso    <= 1'b0;
              miso_oe <= 1'b0;
            end
          end

          default: begin
            state_q <= ST_IDLE;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            bit_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/spi_slave_cpol0_cpha0.md
Name: spi_slave_cpol0_cpha0

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) responder, byte-oriented; the far end of the bus driven by our SPI master.
- Oversamples external sclk/cs_n/mosi with the system clock.
- Shifts in mosi MSB-first and shifts out miso MSB-first from a one-byte transmit holding register.
- Reports each received byte with a one-cycle valid pulse; used where our FPGA logic must answer an external SPI host (debug/host-control port).

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on sclk, cs_n and mosi (legal values 2..3).
- IDLE_BYTE, 8'h00, byte shifted out when the holding register is empty at a byte boundary.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  SPI clock from the host (asynchronous to clk).
- cs_n  input  1  active-low chip select from the host (asynchronous).
- mosi  input  1  host-to-slave serial data (asynchronous).
- miso  output  1  slave-to-host serial data.
- miso_oe  output  1  output enable for the miso pad; 1 only while selected.
- tx_data  input  8  byte to transmit.
- tx_load  input  1  write strobe for tx_data; accepted only when tx_ready=1.
- tx_ready  output  1  1 when the holding register is empty.
- rx_data  output  8  last complete received byte.
- rx_valid  output  1  one-cycle pulse: rx_data updated.
- underrun  output  1  one-cycle pulse: IDLE_BYTE was substituted at a byte start.
- state  output  3  current FSM state, for debug.

Behaviour:
- Reset values (all synchronous on rst): state=IDLE; miso=0; miso_oe=0; tx_ready=1; rx_data=8'h00; rx_valid=0; underrun=0; bit counter=0; shifters=0.
- Input conditioning: sclk, cs_n and mosi each pass through SYNC_STAGES flops, plus one history flop on sclk and cs_n for edge detection.
  - Pin-to-action latency is SYNC_STAGES+1 clk cycles.
  - The host sclk half-period must be at least SYNC_STAGES+2 clk cycles.
- FSM state encodings: IDLE=3'h1, LOAD=3'h2, SHIFT=3'h3, BYTE_DONE=3'h4.
- IDLE:
  - miso_oe=0, counter=0.
  - On synchronized cs_n falling -> LOAD.
- LOAD (exactly one cycle):
  - If holding register full: tx shifter <= hold, and hold is emptied (tx_ready=1 next cycle).
  - If empty: tx shifter <= IDLE_BYTE and underrun pulses.
  - miso <= new shifter[7]; miso_oe=1.
  - Next state: SHIFT.
- SHIFT:
  - Synchronized sclk rising edge: rx shifter <= {rx shifter[6:0], mosi}; counter+1.
    - If counter was 7: go to BYTE_DONE on the same edge.
  - Synchronized sclk falling edge: tx shifter <<1; miso <= shifted[7].
    - The falling edge after the 8th rising edge is absorbed by LOAD, not by SHIFT.
- BYTE_DONE (one cycle):
  - rx_data <= rx shifter; rx_valid=1; counter=0.
  - If cs_n is still low -> LOAD (supports back-to-back bytes); otherwise -> IDLE.
- cs_n rising seen in any state other than BYTE_DONE -> IDLE next cycle:
  - partial byte discarded, no rx_valid; miso_oe=0, miso=0.
  - The holding register is untouched.
- Holding register:
  - tx_load with tx_ready=1 writes tx_data; tx_ready goes 0 the next cycle.
  - tx_load with tx_ready=0 is ignored (no overwrite).
  - tx_load in the same cycle as LOAD with the hold empty: LOAD uses IDLE_BYTE and underrun pulses; the new byte is stored for the following byte.
- sclk edges while in IDLE are ignored; an sclk edge during LOAD/BYTE_DONE is a host timing violation (unspecified).
- rst mid-transfer: immediate return to reset values; the host transfer in progress is lost.

Decomposition:
- Shared package spi_pkg: state encodings (IDLE, LOAD, SHIFT, BYTE_DONE), the SPI mode constants, and the byte width 8, shared with spi_master_cpol0_cpha0.
- One sub-module: spi_sync_edge (parameter SYNC_STAGES; synchronizes one input and outputs the level plus rise/fall pulses). Instantiated for sclk and cs_n; mosi uses a level-only instance.

Test Plan:
- Reset then idle bus -> miso_oe=0, tx_ready=1, rx_valid never pulses, state=3'h1.
- tx_load 8'hA5, host sends 8'h3C with sclk period 16 clk -> host samples miso 8'hA5; rx_data=8'h3C with a single rx_valid pulse; tx_ready=1 after LOAD.
- No tx_load, host sends 8'hFF -> underrun pulses once at LOAD; host receives 8'h00; rx_data=8'hFF.
- Two back-to-back bytes under one cs_n low, host sends 8'h12, 8'h34 (tx_load 8'h55 then 8'hAA) -> host receives 55, AA; two rx_valid pulses with rx_data 12 then 34.
- cs_n deasserted after 5 sclk rises -> no rx_valid; state=IDLE within SYNC_STAGES+2 cycles; the next full transfer of 8'h81 is received correctly.
- rst asserted mid-byte with tx hold full -> all outputs at reset values next cycle, tx_ready=1; a subsequent transfer returns IDLE_BYTE with an underrun pulse.
